// File: rtl/wb_master_pkg.sv
// rtl/wb_master_pkg.sv - shared state encoding, response codes and width helper
package wb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } wb_state_e;

  localparam logic [1:0] WB_RSP_OK      = 2'd0;
  localparam logic [1:0] WB_RSP_ERR     = 2'd1;
  localparam logic [1:0] WB_RSP_RTY     = 2'd2;
  localparam logic [1:0] WB_RSP_TIMEOUT = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_master_ctrl_if.sv
// rtl/wb_master_ctrl_if.sv - command, response and Wishbone signal bundle
interface wb_master_ctrl_if #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 4
);
  localparam int SW = WB_DATA_WIDTH / 8;

  logic                     i_cmd_valid;
  logic                     o_cmd_ready;
  logic                     i_cmd_we;
  logic [WB_ADDR_WIDTH-1:0] i_cmd_adr;
  logic [WB_DATA_WIDTH-1:0] i_cmd_dat;
  logic [SW-1:0]            i_cmd_sel;

  logic                     o_rsp_valid;
  logic                     i_rsp_ready;
  logic [WB_DATA_WIDTH-1:0] o_rsp_dat;
  logic [1:0]               o_rsp_status;

  logic                     o_wb_cyc;
  logic                     o_wb_stb;
  logic                     o_wb_we;
  logic [WB_ADDR_WIDTH-1:0] o_wb_adr;
  logic [WB_DATA_WIDTH-1:0] o_wb_dat;
  logic [SW-1:0]            o_wb_sel;
  logic                     i_wb_stall;
  logic                     i_wb_ack;
  logic                     i_wb_err;
  logic                     i_wb_rty;
  logic [WB_DATA_WIDTH-1:0] i_wb_dat;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_dat, i_cmd_sel, i_rsp_ready,
    input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_rty, i_wb_dat,
    output o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_status,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_dat, i_cmd_sel, i_rsp_ready,
    output i_wb_stall, i_wb_ack, i_wb_err, i_wb_rty, i_wb_dat,
    input  o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_status,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel
  );
endinterface

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - saturating bus-cycle age counter
module wb_timeout_cnt
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  input  logic en,
  output logic o_expired
);
  localparam int CW = clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != LAST)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q == LAST);
endmodule

// File: rtl/wb_master_ctrl.sv
// rtl/wb_master_ctrl.sv - single-beat Wishbone B4 pipelined initiator
module wb_master_ctrl
  import wb_master_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              res,
  wb_master_ctrl_if.master bus
);
  localparam int SW = WB_DATA_WIDTH / 8;

  wb_state_e                state_q, state_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     cyc_q, cyc_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SW-1:0]            sel_q, sel_d;
  logic [WB_DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]               rsp_status_q, rsp_status_d;
  logic                     accept, term, expired;

  assign accept = (state_q == ST_IDLE) && bus.i_cmd_valid;
  assign term   = bus.i_wb_ack | bus.i_wb_err | bus.i_wb_rty;

  wb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .res       (res),
    .clr       (accept),
    .en        (cyc_q),
    .o_expired (expired)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      ST_IDLE: if (bus.i_cmd_valid) begin
        state_d = ST_REQ;
        we_d    = bus.i_cmd_we;
        adr_d   = bus.i_cmd_adr;
        dat_d   = bus.i_cmd_dat;
        sel_d   = bus.i_cmd_sel;
      end
      ST_REQ: begin
        if (term || expired)    state_d = ST_RSP;
        else if (!bus.i_wb_stall) state_d = ST_WAIT;
      end
      ST_WAIT: if (term || expired) state_d = ST_RSP;
      ST_RSP:  if (bus.i_rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A termination seen in the expiry cycle still wins over the timeout.
    if ((state_q == ST_REQ || state_q == ST_WAIT) && state_d == ST_RSP) begin
      rsp_dat_d = '0;
      if (bus.i_wb_err)      rsp_status_d = WB_RSP_ERR;
      else if (bus.i_wb_rty) rsp_status_d = WB_RSP_RTY;
      else if (bus.i_wb_ack) begin
        rsp_status_d = WB_RSP_OK;
        if (!we_q) rsp_dat_d = bus.i_wb_dat;
      end
      else rsp_status_d = WB_RSP_TIMEOUT;
    end

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RSP);
    cyc_d       = (state_d == ST_REQ) || (state_d == ST_WAIT);
    stb_d       = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= WB_RSP_OK;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign bus.o_cmd_ready  = cmd_ready_q;
  assign bus.o_rsp_valid  = rsp_valid_q;
  assign bus.o_rsp_dat    = rsp_dat_q;
  assign bus.o_rsp_status = rsp_status_q;
  assign bus.o_wb_cyc     = cyc_q;
  assign bus.o_wb_stb     = stb_q;
  assign bus.o_wb_we      = we_q;
  assign bus.o_wb_adr     = adr_q;
  assign bus.o_wb_dat     = dat_q;
  assign bus.o_wb_sel     = sel_q;
endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb/tb_wb_master_ctrl.sv - directed bench for wb_master_ctrl
module tb_wb_master_ctrl;
  import wb_master_pkg::*;

  logic clk;
  logic res;
  int   n_checks;
  int   n_errors;

  logic [1:0]  st;
  logic [31:0] rd;
  int          lat, stb_n, cyc_n;
  bit          stable;

  wb_master_ctrl_if #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(4)) bus ();

  wb_master_ctrl #(
    .WB_DATA_WIDTH (32),
    .WB_ADDR_WIDTH (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // term bits are {err, rty, ack}, raised in the term_at-th cycle of cyc
  task automatic do_cmd(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, input int stall_n, input int term_at,
                        input logic [2:0] term, input logic [31:0] rdat, input int hold,
                        output logic [1:0] o_st, output logic [31:0] o_rd, output int o_lat,
                        output int o_stb, output int o_cyc, output bit o_stable);
    int guard;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = we;
    bus.i_cmd_adr   = adr;
    bus.i_cmd_dat   = wdat;
    bus.i_cmd_sel   = sel;
    bus.i_rsp_ready = 1'b0;
    o_stable = 1'b1;
    tick();
    bus.i_cmd_valid = 1'b0;
    o_lat = 0; o_stb = 0; o_cyc = 0; guard = 0;
    while (!bus.o_rsp_valid && guard < 200) begin
      if (bus.o_wb_cyc) o_cyc++;
      if (bus.o_wb_stb) begin
        o_stb++;
        if (bus.o_wb_adr !== adr || bus.o_wb_sel !== sel || bus.o_wb_we !== we) o_stable = 1'b0;
        if (we && bus.o_wb_dat !== wdat) o_stable = 1'b0;
      end
      bus.i_wb_stall = bus.o_wb_stb && (o_stb <= stall_n);
      {bus.i_wb_err, bus.i_wb_rty, bus.i_wb_ack} =
        (bus.o_wb_cyc && o_cyc == term_at) ? term : 3'b000;
      bus.i_wb_dat = rdat;
      tick();
      o_lat++;
      guard++;
    end
    chk("rsp_seen", 32'(bus.o_rsp_valid), 32'd1);
    {bus.i_wb_err, bus.i_wb_rty, bus.i_wb_ack, bus.i_wb_stall} = 4'b0000;
    o_st = bus.o_rsp_status;
    o_rd = bus.o_rsp_dat;
    for (int i = 0; i < hold; i++) begin
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_adr   = 4'hF;
      tick();
      if (!bus.o_rsp_valid || bus.o_rsp_status !== o_st || bus.o_rsp_dat !== o_rd ||
          bus.o_cmd_ready || bus.o_wb_cyc) o_stable = 1'b0;
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    res = 1'b1;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_we = 1'b0; bus.i_cmd_adr = '0;
    bus.i_cmd_dat = '0; bus.i_cmd_sel = '0; bus.i_rsp_ready = 1'b0;
    bus.i_wb_stall = 1'b0; bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0;
    bus.i_wb_rty = 1'b0; bus.i_wb_dat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_cyc", 32'(bus.o_wb_cyc), 32'd0);
    chk("rst_stb", 32'(bus.o_wb_stb), 32'd0);
    chk("rst_we", 32'(bus.o_wb_we), 32'd0);
    chk("rst_adr", 32'(bus.o_wb_adr), 32'd0);
    chk("rst_dat", bus.o_wb_dat, 32'd0);
    chk("rst_sel", 32'(bus.o_wb_sel), 32'd0);
    chk("rst_rsp_dat", bus.o_rsp_dat, 32'd0);
    chk("rst_rsp_status", 32'(bus.o_rsp_status), 32'd0);
    #3 res = 1'b0;
    tick();

    // slave terminations outside a cycle must be ignored
    bus.i_wb_ack = 1'b1; bus.i_wb_err = 1'b1;
    tick();
    chk("idle_ign_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("idle_ign_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
    bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0;

    do_cmd(1'b1, 4'h0, 32'h0000_0401, 4'hF, 0, 2, 3'b001, 32'hDEAD_BEEF, 0,
           st, rd, lat, stb_n, cyc_n, stable);
    chk("wr_status", 32'(st), 32'(WB_RSP_OK));
    chk("wr_rsp_dat", rd, 32'd0);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_stb_cycles", 32'(stb_n), 32'd1);
    chk("wr_cyc_cycles", 32'(cyc_n), 32'd2);
    chk("wr_bus_stable", 32'(stable), 32'd1);

    do_cmd(1'b0, 4'h4, 32'h0, 4'hF, 3, 5, 3'b001, 32'hCAFE_0042, 0,
           st, rd, lat, stb_n, cyc_n, stable);
    chk("rd_status", 32'(st), 32'(WB_RSP_OK));
    chk("rd_rsp_dat", rd, 32'hCAFE_0042);
    chk("rd_latency", 32'(lat), 32'd5);
    chk("rd_stb_cycles", 32'(stb_n), 32'd4);
    chk("rd_cyc_cycles", 32'(cyc_n), 32'd5);
    chk("rd_bus_stable", 32'(stable), 32'd1);

    do_cmd(1'b0, 4'h4, 32'h0, 4'hF, 0, 2, 3'b101, 32'h1111_2222, 0,
           st, rd, lat, stb_n, cyc_n, stable);
    chk("err_ack_status", 32'(st), 32'(WB_RSP_ERR));
    chk("err_ack_rsp_dat", rd, 32'd0);

    do_cmd(1'b0, 4'h8, 32'h0, 4'h3, 0, 2, 3'b010, 32'h3333_4444, 0,
           st, rd, lat, stb_n, cyc_n, stable);
    chk("rty_status", 32'(st), 32'(WB_RSP_RTY));
    chk("rty_rsp_dat", rd, 32'd0);

    do_cmd(1'b0, 4'hC, 32'h0, 4'hF, 0, 0, 3'b000, 32'h5555_6666, 0,
           st, rd, lat, stb_n, cyc_n, stable);
    chk("tmo_status", 32'(st), 32'(WB_RSP_TIMEOUT));
    chk("tmo_cyc_cycles", 32'(cyc_n), 32'd8);
    chk("tmo_rsp_dat", rd, 32'd0);

    do_cmd(1'b0, 4'hC, 32'h0, 4'hF, 0, 8, 3'b001, 32'h7777_8888, 0,
           st, rd, lat, stb_n, cyc_n, stable);
    chk("ack8_status", 32'(st), 32'(WB_RSP_OK));
    chk("ack8_cyc_cycles", 32'(cyc_n), 32'd8);
    chk("ack8_rsp_dat", rd, 32'h7777_8888);

    do_cmd(1'b1, 4'h8, 32'h1234_5678, 4'h3, 1, 3, 3'b001, 32'h0, 5,
           st, rd, lat, stb_n, cyc_n, stable);
    chk("bp_status", 32'(st), 32'(WB_RSP_OK));
    chk("bp_held_stable", 32'(stable), 32'd1);
    chk("bp_after_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
    chk("bp_after_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);

    bus.i_cmd_valid = 1'b1; bus.i_cmd_we = 1'b1; bus.i_cmd_adr = 4'h2;
    bus.i_cmd_dat = 32'hA5A5_A5A5; bus.i_cmd_sel = 4'hF;
    tick();
    bus.i_cmd_valid = 1'b0;
    tick();
    chk("mid_wait_cyc", 32'(bus.o_wb_cyc), 32'd1);
    chk("mid_wait_stb", 32'(bus.o_wb_stb), 32'd0);
    #2 res = 1'b1;
    #1;
    chk("mid_rst_cyc", 32'(bus.o_wb_cyc), 32'd0);
    chk("mid_rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
    #2 res = 1'b0;
    tick();
    bus.i_wb_ack = 1'b1;
    tick();
    bus.i_wb_ack = 1'b0;
    chk("mid_rst_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    chk("mid_rst_idle", 32'(bus.o_cmd_ready), 32'd1);

    do_cmd(1'b1, 4'h0, 32'h0000_0401, 4'hF, 0, 2, 3'b001, 32'h0, 0,
           st, rd, lat, stb_n, cyc_n, stable);
    chk("post_rst_status", 32'(st), 32'(WB_RSP_OK));
    chk("post_rst_latency", 32'(lat), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_master_ctrl.md
# wb_master_ctrl

Hardware Wishbone B4 pipelined initiator that drives the register slaves (watchdog `wdg_top`, mtime) from a simple valid/ready command port. Each accepted command becomes exactly one single-beat Wishbone cycle, with stall back-pressure, ACK/ERR/RTY termination and a bounded timeout. It sits between a core-side request source (CPU load/store unit or a hardware watchdog kicker) and the peripheral Wishbone bus. It is the RTL counterpart of the bench's `wishbone_transaction` task.

## Interface
- `WB_DATA_WIDTH`, 32: Wishbone data width; `sel` width is `WB_DATA_WIDTH/8`.
- `WB_ADDR_WIDTH`, 4: Wishbone address width.
- `TIMEOUT_CYCLES`, 1024: cycles from `o_wb_cyc` rising to forced abort; must be ≥ 2.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `res` in 1: asynchronous reset, active-high.
- `i_cmd_valid` in 1: command present.
- `o_cmd_ready` out 1: command accepted when `i_cmd_valid & o_cmd_ready`.
- `i_cmd_we` in 1: 1 = write, 0 = read.
- `i_cmd_adr` in `WB_ADDR_WIDTH`: target address.
- `i_cmd_dat` in `WB_DATA_WIDTH`: write data.
- `i_cmd_sel` in `WB_DATA_WIDTH/8`: byte selects.
- `o_rsp_valid` out 1: response present.
- `i_rsp_ready` in 1: response consumed when `o_rsp_valid & i_rsp_ready`.
- `o_rsp_dat` out `WB_DATA_WIDTH`: read data, or 0 for writes, timeouts and errors.
- `o_rsp_status` out 2: 0 OK, 1 ERR, 2 RTY, 3 TIMEOUT.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1: Wishbone cycle, strobe and write enable.
- `o_wb_adr` out `WB_ADDR_WIDTH`; `o_wb_dat` out `WB_DATA_WIDTH`; `o_wb_sel` out `WB_DATA_WIDTH/8`.
- `i_wb_stall`, `i_wb_ack`, `i_wb_err`, `i_wb_rty` in 1: slave handshake.
- `i_wb_dat` in `WB_DATA_WIDTH`: slave read data.

## Operation
The controller is a four-state FSM: IDLE, REQ, WAIT, RSP.
- **IDLE:** `o_cmd_ready` = 1, and only in this state. On command accept, register `we/adr/dat/sel` into the bus outputs and go to REQ.
- **REQ:** `o_wb_cyc` = `o_wb_stb` = 1.
  - Hold the strobe while `i_wb_stall` = 1.
  - The strobe is taken on the first cycle with `i_wb_stall` = 0. Then go to WAIT, or straight to RSP if a termination is also present in that cycle.
  - Termination inputs seen while stalled also terminate the cycle.
- **WAIT:** `o_wb_cyc` = 1, `o_wb_stb` = 0. Leave for RSP on `i_wb_ack | i_wb_err | i_wb_rty`.
- **Termination priority:** ERR > RTY > ACK when inputs coincide.
- **Read data:** `i_wb_dat` is captured on ACK of a read only.
- **RSP:** `o_wb_cyc` = 0, `o_rsp_valid` = 1. Response fields are held stable until `i_rsp_ready`, then return to IDLE. If `i_rsp_ready` is already high on entry, the handshake completes in that cycle.
- **Timeout:**
  - The counter clears on IDLE→REQ and increments every cycle in REQ/WAIT.
  - When it reaches `TIMEOUT_CYCLES - 1` with no termination, drop `cyc/stb` and go to RSP with status TIMEOUT.
  - A termination in that same cycle wins over the timeout.
- **No retry:** RTY is reported to the requester only.
- **Outputs while `o_wb_cyc` = 0:** `o_wb_we/adr/dat/sel` keep their last value, and `o_wb_stb` = 0.

## Timing
- **Reset:** async reset forces IDLE. `o_cmd_ready` = 1; `o_rsp_valid`, `o_wb_cyc`, `o_wb_stb` and `o_wb_we` = 0. `o_wb_adr/dat/sel`, `o_rsp_dat` and `o_rsp_status` are all 0.
- **Reset mid-cycle:** `cyc` is dropped immediately and asynchronously, and no response is produced for the aborted command.
- **Best case, zero-stall slave that acks in the cycle after the strobe:**
  - accept at edge N;
  - `cyc/stb` high after N;
  - ACK sampled at N+2;
  - `o_rsp_valid` high after N+2.
  - Latency from command to response is 2 cycles.
- **Throughput:** one command per 3 cycles at best, since IDLE and RSP each take one cycle.
- **Outputs:** all outputs are registered; there is no combinational path from `i_wb_*` to `o_wb_*`.
- **Slave input sampling:** ACK/ERR/RTY are ignored whenever `o_wb_cyc` = 0, i.e. in IDLE and RSP.

## Structure
- **Package `wb_master_pkg`:**
  - the state encoding (IDLE = 0, REQ = 1, WAIT = 2, RSP = 3);
  - the status codes `WB_RSP_OK/ERR/RTY/TIMEOUT`;
  - the `clog2` helper for the counter width.
- **Sub-module `wb_timeout_cnt`:** a saturating counter of width `clog2(TIMEOUT_CYCLES)`. Ports are `clk`, `res`, `clr`, `en`, and `o_expired`, which asserts when the count equals `TIMEOUT_CYCLES - 1`.
- **Top level:** the FSM, the bus registers and the response registers.

## Test plan
- **Write to the watchdog:** write `adr` 0x0, data 0x0000_0401, `sel` 0xF to `wdg_top`, with stall 0. Expect `cyc/stb` one cycle later, `stb` for one cycle, response status OK, `o_rsp_dat` = 0, and total latency 2 cycles.
- **Read with stall:** read `adr` 0x4 while the slave stalls 3 cycles. Expect `stb` held 4 cycles with adr/sel stable, `o_rsp_dat` equal to the slave counter value, and status OK.
- **Simultaneous termination:** present ERR and ACK in the same cycle. Expect status ERR and `o_rsp_dat` = 0; separately, RTY alone gives status RTY.
- **Timeout:** with `TIMEOUT_CYCLES` = 8 and a slave that never acks, expect `cyc` dropped exactly 8 cycles after it rose and status TIMEOUT. In a second run, ACK on the 8th cycle gives status OK.
- **Response back-pressure:** hold `i_rsp_ready` = 0 for 5 cycles. The response stays stable, `o_cmd_ready` = 0 throughout, and a second `i_cmd_valid` is not accepted until the handshake completes.
- **Reset mid-operation:** assert `res` during WAIT. Expect `cyc` = 0 with no clock edge, IDLE afterwards, `o_rsp_valid` = 0, and a following command completing normally.
